bus_source_arbiter: RTL and testbench
=====================================

BUS_SOURCE_ARBITER -- requirements
Module: bus_source_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_SRC, default 32: number of bus sources; fixed at 32 to match the 5-bit bus select.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 16: grant watchdog limit; used only when BUS_ARB_TIMEOUT_EN is defined.
REQ-003 The block SHALL have port clock, input, 1: sole clock; all state changes on the rising edge.
REQ-004 The block SHALL have port clear, input, 1: reset; synchronous and active-high.
REQ-005 The block SHALL have port req, input, 32: bus-drive request per source; bit i corresponds to source i.
REQ-006 The block SHALL have port done, input, 1: the granted source has finished its bus transfer.
REQ-007 The block SHALL have port grant, output, 32: one-hot bus-drive enable, which feeds the 32-to-5 bus select encoder.
REQ-008 The block SHALL have port grant_valid, output, 1: high exactly when grant is non-zero.
REQ-009 The block SHALL have port busy, output, 1: high in states GRANT and TURN.
REQ-010 The block SHALL have port timeout, output, 1: sticky watchdog flag; present only when BUS_ARB_TIMEOUT_EN is defined.

Function
REQ-011 The block SHALL implement a state machine with states IDLE, GRANT and TURN; all outputs SHALL be registered.
REQ-012 grant SHALL be all-zero or exactly one-hot on every cycle; a multi-hot value is a design error.
REQ-013 IDLE, req==0: the block SHALL remain in IDLE with grant=0.
REQ-014 IDLE, req!=0 at edge k: the block SHALL go to GRANT and drive the selected one-hot grant from edge k onward (1-cycle latency).
REQ-015 Selection SHALL be round-robin: search from (last_idx+1) mod 32 upward, wrapping 31->0; the first set req bit wins; last_idx SHALL update to the winner.
REQ-016 In GRANT, grant SHALL be held constant regardless of req changes, including deassertion of the granted bit.
REQ-017 GRANT, done=1 at edge n: grant SHALL be 0 after edge n, and the state SHALL become TURN.
REQ-018 TURN SHALL last exactly one cycle with grant=0 (bus turnaround), then go to IDLE unconditionally.
REQ-019 Minimum spacing SHALL be: done sampled at edge n gives the next grant after edge n+2.
REQ-020 done SHALL be ignored in IDLE and TURN.
REQ-021 A single persistent requester SHALL be re-granted after each TURN/IDLE pair.

Reset
REQ-022 clear=1 at an edge SHALL set state=IDLE, grant=0, grant_valid=0, busy=0, last_idx=31 (so the first search starts at bit 0), watchdog count=0 and timeout=0.
REQ-023 clear SHALL override done and req in the same cycle.
REQ-024 clear asserted mid-GRANT SHALL drop grant after that edge, with no TURN cycle.

Configuration
REQ-025 When macro BUS_ARB_TIMEOUT_EN is defined, a counter SHALL run in GRANT.
REQ-026 With BUS_ARB_TIMEOUT_EN defined, if done is still absent after TIMEOUT_CYCLES grant cycles, the block SHALL force the GRANT->TURN transition exactly as if done=1.
REQ-027 With BUS_ARB_TIMEOUT_EN defined, a forced release SHALL set timeout=1, and timeout SHALL stay set until clear.
REQ-028 With BUS_ARB_TIMEOUT_EN defined, the counter SHALL reset on entry to GRANT.
REQ-029 When BUS_ARB_TIMEOUT_EN is undefined, there SHALL be no counter and no timeout port, and GRANT SHALL wait indefinitely for done.

Structure
REQ-030 Package bus_arb_pkg SHALL hold: the state enum (IDLE, GRANT, TURN); NUM_SRC=32; IDX_W=5; the default TIMEOUT_CYCLES.
REQ-031 Sub-module rr_pick SHALL be combinational, with inputs req[31:0] and last_idx[4:0] and outputs one-hot winner[31:0] and winner_idx[4:0].
REQ-032 rr_pick SHALL be instantiated once by bus_source_arbiter.

Verification
REQ-033 Bench: after clear, req=32'h00000010 -> grant=32'h00000010 and grant_valid=1 one edge later; done pulse -> grant=0 for one TURN cycle, then re-grant of bit 4.
REQ-034 Bench: req=32'h80000003 held, done every grant -> grant sequence 0x00000001, 0x00000002, 0x80000000, 0x00000001, ...
REQ-035 Bench: granted source drops req mid-GRANT -> grant is unchanged until done is sampled.
REQ-036 Bench: clear during GRANT with done=1 in the same cycle -> grant=0, state IDLE, and the next req=0xFFFFFFFF grants bit 0.
REQ-037 Bench: with BUS_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, done held 0 -> grant drops after 16 grant cycles and timeout=1 until clear.
REQ-038 Bench: all benches -> assert grant is zero or one-hot, and grant_valid equals (grant!=0), on every cycle.

Source files
------------

// File: rtl/bus_source_arbiter_pkg.sv
// Shared types and constants for the 32-source round-robin bus arbiter.
// Optional grant watchdog is enabled by defining BUS_ARB_TIMEOUT_EN.
package bus_arb_pkg;

    localparam int unsigned NUM_SRC        = 32;
    localparam int unsigned IDX_W          = 5;
    localparam int unsigned TIMEOUT_CYCLES = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_e;

    // True when the vector has at most one bit set.
    function automatic logic onehot0(input logic [NUM_SRC-1:0] v);
        return (v & (v - {{(NUM_SRC-1){1'b0}}, 1'b1})) == {NUM_SRC{1'b0}};
    endfunction

endpackage

// File: rtl/bus_source_arbiter_if.sv
// Request/grant bundle between the bus sources and the arbiter.
// The timeout flag exists only when BUS_ARB_TIMEOUT_EN is defined.
interface bus_source_arbiter_if;
    import bus_arb_pkg::*;

    logic [NUM_SRC-1:0] req;
    logic               done;
    logic [NUM_SRC-1:0] grant;
    logic               grant_valid;
    logic               busy;
`ifdef BUS_ARB_TIMEOUT_EN
    logic               timeout;
`endif

    modport slave (
        input  req,
        input  done,
        output grant,
        output grant_valid,
`ifdef BUS_ARB_TIMEOUT_EN
        output timeout,
`endif
        output busy
    );

    modport master (
        output req,
        output done,
        input  grant,
        input  grant_valid,
`ifdef BUS_ARB_TIMEOUT_EN
        input  timeout,
`endif
        input  busy
    );

endinterface

// File: rtl/bus_source_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after last_idx+1,
// wrapping 31 -> 0. Returns an all-zero winner when no request is set.
module rr_pick
    import bus_arb_pkg::*;
(
    input  logic [NUM_SRC-1:0] req,
    input  logic [IDX_W-1:0]   last_idx,
    output logic [NUM_SRC-1:0] winner,
    output logic [IDX_W-1:0]   winner_idx
);

    logic             found_s;
    logic [IDX_W-1:0] probe_s;

    // Scan all 32 positions starting one past the previous winner.
    always_comb begin
        found_s    = 1'b0;
        winner_idx = {IDX_W{1'b0}};
        probe_s    = {IDX_W{1'b0}};
        for (int i = 0; i < NUM_SRC; i++) begin
            probe_s = last_idx + IDX_W'(1) + IDX_W'(i);
            if (!found_s && req[probe_s]) begin
                found_s    = 1'b1;
                winner_idx = probe_s;
            end else begin
                found_s    = found_s;
            end
        end
    end

    // Decode the chosen index back to a one-hot enable.
    always_comb begin
        if (found_s) begin
            winner = {{(NUM_SRC-1){1'b0}}, 1'b1} << winner_idx;
        end else begin
            winner = {NUM_SRC{1'b0}};
        end
    end

endmodule

// File: rtl/bus_source_arbiter.sv
// Round-robin bus-drive arbiter: IDLE -> GRANT (held until done) -> TURN -> IDLE.
// Define BUS_ARB_TIMEOUT_EN to add the grant watchdog and sticky timeout flag.
module bus_source_arbiter
    import bus_arb_pkg::*;
#(
    parameter int unsigned NUM_SRC        = bus_arb_pkg::NUM_SRC,
    parameter int unsigned TIMEOUT_CYCLES = bus_arb_pkg::TIMEOUT_CYCLES
) (
    input  logic                 clock,
    input  logic                 clear,
    bus_source_arbiter_if.slave  bus
);

    state_e             state_r;
    state_e             state_nxt_s;
    logic [NUM_SRC-1:0] grant_r;
    logic [NUM_SRC-1:0] grant_nxt_s;
    logic               grant_valid_r;
    logic               busy_r;
    logic [IDX_W-1:0]   last_idx_r;
    logic [IDX_W-1:0]   last_idx_nxt_s;
    logic [NUM_SRC-1:0] winner_s;
    logic [IDX_W-1:0]   winner_idx_s;
    logic               release_s;

    rr_pick u_rr_pick (
        .req        (bus.req),
        .last_idx   (last_idx_r),
        .winner     (winner_s),
        .winner_idx (winner_idx_s)
    );

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] wd_cnt_r;
    logic             timeout_r;
    logic             forced_s;

    // The watchdog fires on the last permitted grant cycle only if done is absent.
    always_comb begin
        if (state_r == GRANT) begin
            forced_s = !bus.done && (wd_cnt_r == CNT_LIMIT);
        end else begin
            forced_s = 1'b0;
        end
        release_s = bus.done || forced_s;
    end

    // Watchdog counter and sticky timeout flag.
    always_ff @(posedge clock) begin
        if (clear) begin
            wd_cnt_r  <= {CNT_W{1'b0}};
            timeout_r <= 1'b0;
        end else begin
            if (state_r == GRANT && !release_s) begin
                wd_cnt_r <= wd_cnt_r + CNT_W'(1);
            end else begin
                wd_cnt_r <= {CNT_W{1'b0}};
            end
            if (forced_s) begin
                timeout_r <= 1'b1;
            end else begin
                timeout_r <= timeout_r;
            end
        end
    end

    assign bus.timeout = timeout_r;
`else
    // Without the watchdog a grant is held until the source reports done.
    always_comb begin
        release_s = bus.done;
    end
`endif

    // Next-state and next-grant selection.
    always_comb begin
        state_nxt_s    = state_r;
        grant_nxt_s    = grant_r;
        last_idx_nxt_s = last_idx_r;
        case (state_r)
            IDLE: begin
                if (|bus.req) begin
                    state_nxt_s    = GRANT;
                    grant_nxt_s    = winner_s;
                    last_idx_nxt_s = winner_idx_s;
                end else begin
                    grant_nxt_s    = {NUM_SRC{1'b0}};
                end
            end
            GRANT: begin
                if (release_s) begin
                    state_nxt_s = TURN;
                    grant_nxt_s = {NUM_SRC{1'b0}};
                end else begin
                    grant_nxt_s = grant_r;
                end
            end
            TURN: begin
                state_nxt_s = IDLE;
                grant_nxt_s = {NUM_SRC{1'b0}};
            end
            default: begin
                state_nxt_s = IDLE;
                grant_nxt_s = {NUM_SRC{1'b0}};
            end
        endcase
    end

    // State and registered outputs; clear wins over every other input.
    always_ff @(posedge clock) begin
        if (clear) begin
            state_r       <= IDLE;
            grant_r       <= {NUM_SRC{1'b0}};
            grant_valid_r <= 1'b0;
            busy_r        <= 1'b0;
            last_idx_r    <= {IDX_W{1'b1}};
        end else begin
            state_r       <= state_nxt_s;
            grant_r       <= grant_nxt_s;
            grant_valid_r <= |grant_nxt_s;
            busy_r        <= (state_nxt_s == GRANT) || (state_nxt_s == TURN);
            last_idx_r    <= last_idx_nxt_s;
        end
    end

    assign bus.grant       = grant_r;
    assign bus.grant_valid = grant_valid_r;
    assign bus.busy        = busy_r;

endmodule

// File: tb/tb_bus_source_arbiter.sv
// Directed-vector bench for bus_source_arbiter; watchdog checks run when
// BUS_ARB_TIMEOUT_EN is defined.
module tb_bus_source_arbiter;
    import bus_arb_pkg::*;

    logic clock = 1'b0;
    logic clear = 1'b0;
    int   n_vec  = 0;
    int   n_miss = 0;

    bus_source_arbiter_if bus_if ();

    bus_source_arbiter #(.NUM_SRC(32), .TIMEOUT_CYCLES(16)) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus_if.slave)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        clr;
        logic [31:0] req;
        logic        done;
        logic [31:0] eg;
        logic        ev;
        logic        eb;
    } vec_t;

    vec_t tbl [$];

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic clr, input logic [31:0] req, input logic done);
        @(negedge clock);
        clear       = clr;
        bus_if.req  = req;
        bus_if.done = done;
        @(posedge clock);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [31:0] eg, input logic ev, input logic eb);
        cmp({tag, ".grant"}, bus_if.grant, eg);
        cmp({tag, ".grant_valid"}, {31'd0, bus_if.grant_valid}, {31'd0, ev});
        cmp({tag, ".busy"}, {31'd0, bus_if.busy}, {31'd0, eb});
    endtask

    function automatic vec_t v(input logic clr, input logic [31:0] req, input logic done,
                               input logic [31:0] eg, input logic eb);
        vec_t r;
        r.clr = clr; r.req = req; r.done = done;
        r.eg = eg; r.ev = (eg != 32'd0); r.eb = eb;
        return r;
    endfunction

    // Every-cycle structural check on the grant vector.
    always @(negedge clock) begin
        if (n_vec > 0) begin
            cmp("grant_onehot0", {31'd0, onehot0(bus_if.grant)}, 32'd1);
            cmp("valid_vs_grant", {31'd0, bus_if.grant_valid}, {31'd0, (bus_if.grant != 32'd0)});
        end
    end

    initial begin
        bus_if.req  = 32'd0;
        bus_if.done = 1'b0;

        // single requester, turnaround, re-grant
        tbl.push_back(v(1'b1, 32'h0,        1'b0, 32'h0,        1'b0));
        tbl.push_back(v(1'b0, 32'h10,       1'b0, 32'h10,       1'b1));
        tbl.push_back(v(1'b0, 32'h10,       1'b0, 32'h10,       1'b1));
        tbl.push_back(v(1'b0, 32'h10,       1'b1, 32'h0,        1'b1));
        tbl.push_back(v(1'b0, 32'h10,       1'b0, 32'h0,        1'b0));
        tbl.push_back(v(1'b0, 32'h10,       1'b0, 32'h10,       1'b1));
        tbl.push_back(v(1'b0, 32'h0,        1'b1, 32'h0,        1'b1));
        tbl.push_back(v(1'b0, 32'h0,        1'b0, 32'h0,        1'b0));
        // round robin over bits 0,1,31 with wrap; clear overrides req/done
        tbl.push_back(v(1'b1, 32'h80000003, 1'b1, 32'h0,        1'b0));
        tbl.push_back(v(1'b0, 32'h80000003, 1'b0, 32'h1,        1'b1));
        tbl.push_back(v(1'b0, 32'h80000003, 1'b1, 32'h0,        1'b1));
        tbl.push_back(v(1'b0, 32'h80000003, 1'b0, 32'h0,        1'b0));
        tbl.push_back(v(1'b0, 32'h80000003, 1'b0, 32'h2,        1'b1));
        tbl.push_back(v(1'b0, 32'h80000003, 1'b1, 32'h0,        1'b1));
        tbl.push_back(v(1'b0, 32'h80000003, 1'b0, 32'h0,        1'b0));
        tbl.push_back(v(1'b0, 32'h80000003, 1'b0, 32'h80000000, 1'b1));
        tbl.push_back(v(1'b0, 32'h80000003, 1'b1, 32'h0,        1'b1));
        tbl.push_back(v(1'b0, 32'h80000003, 1'b0, 32'h0,        1'b0));
        tbl.push_back(v(1'b0, 32'h80000003, 1'b0, 32'h1,        1'b1));
        // granted source drops req: grant holds until done
        tbl.push_back(v(1'b0, 32'h2,        1'b0, 32'h1,        1'b1));
        tbl.push_back(v(1'b0, 32'h0,        1'b0, 32'h1,        1'b1));
        tbl.push_back(v(1'b0, 32'h0,        1'b1, 32'h0,        1'b1));
        tbl.push_back(v(1'b0, 32'h0,        1'b0, 32'h0,        1'b0));
        tbl.push_back(v(1'b0, 32'h0,        1'b0, 32'h0,        1'b0));
        // search resumes after bit 0; clear+done mid-GRANT; restart from bit 0
        tbl.push_back(v(1'b0, 32'h100,      1'b0, 32'h100,      1'b1));
        tbl.push_back(v(1'b1, 32'hFFFFFFFF, 1'b1, 32'h0,        1'b0));
        tbl.push_back(v(1'b0, 32'hFFFFFFFF, 1'b0, 32'h1,        1'b1));
        tbl.push_back(v(1'b0, 32'hFFFFFFFF, 1'b1, 32'h0,        1'b1));
        // done ignored in TURN and IDLE
        tbl.push_back(v(1'b0, 32'hFFFFFFFF, 1'b1, 32'h0,        1'b0));
        tbl.push_back(v(1'b0, 32'hFFFFFFFF, 1'b1, 32'h2,        1'b1));
        tbl.push_back(v(1'b0, 32'hFFFFFFFF, 1'b0, 32'h2,        1'b1));
        tbl.push_back(v(1'b0, 32'hFFFFFFFF, 1'b1, 32'h0,        1'b1));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].clr, tbl[i].req, tbl[i].done);
            chk_out($sformatf("vec%0d", i), tbl[i].eg, tbl[i].ev, tbl[i].eb);
        end

`ifdef BUS_ARB_TIMEOUT_EN
        step(1'b1, 32'h0, 1'b0);
        cmp("wd.reset_timeout", {31'd0, bus_if.timeout}, 32'd0);
        step(1'b0, 32'h8, 1'b0);
        chk_out("wd.first", 32'h8, 1'b1, 1'b1);
        for (int i = 1; i < 16; i++) begin
            step(1'b0, 32'h8, 1'b0);
            cmp($sformatf("wd.hold%0d", i), bus_if.grant, 32'h8);
        end
        cmp("wd.no_early_timeout", {31'd0, bus_if.timeout}, 32'd0);
        step(1'b0, 32'h8, 1'b0);
        chk_out("wd.forced", 32'h0, 1'b0, 1'b1);
        cmp("wd.timeout_set", {31'd0, bus_if.timeout}, 32'd1);
        step(1'b0, 32'h8, 1'b0);
        chk_out("wd.idle", 32'h0, 1'b0, 1'b0);
        step(1'b0, 32'h8, 1'b0);
        chk_out("wd.regrant", 32'h8, 1'b1, 1'b1);
        step(1'b0, 32'h8, 1'b1);
        cmp("wd.sticky", {31'd0, bus_if.timeout}, 32'd1);
        step(1'b1, 32'h8, 1'b0);
        cmp("wd.cleared", {31'd0, bus_if.timeout}, 32'd0);
        chk_out("wd.clear_out", 32'h0, 1'b0, 1'b0);
`else
        step(1'b1, 32'h0, 1'b0);
        step(1'b0, 32'h8, 1'b0);
        chk_out("hold.first", 32'h8, 1'b1, 1'b1);
        for (int i = 1; i < 40; i++) begin
            step(1'b0, 32'h8, 1'b0);
        end
        chk_out("hold.after40", 32'h8, 1'b1, 1'b1);
        step(1'b0, 32'h8, 1'b1);
        chk_out("hold.release", 32'h0, 1'b0, 1'b1);
`endif

        @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
